// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-write register file.
//   wr_port_t   - one write-back port bundle (en, addr, data), sized to the
//                 largest supported address/data width; narrower users
//                 zero-extend into it.
//   addr_width  - address width needed to index a register file.
package regfile_pkg;

  localparam int unsigned WR_AW_MAX = 10;
  localparam int unsigned WR_DW_MAX = 64;

  typedef struct packed {
    logic                 en;
    logic [WR_AW_MAX-1:0] addr;
    logic [WR_DW_MAX-1:0] data;
  } wr_port_t;

  // Never returns 0 so a 1-register corner still gets a legal port width.
  function automatic int unsigned addr_width(input int unsigned num_reg);
    return (num_reg < 2) ? 1 : $clog2(num_reg);
  endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// regfile_wr_sel: priority select of the write-back ports for one index.
//   ports  - all write ports (zero-extended bundles)
//   idx    - register index to match (constant for storage, live for bypass)
//   we_c   - some enabled port targets idx
//   data_c - data of the highest-index enabled port targeting idx
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned DW     = 32
) (
  input  wr_port_t [NUM_WR-1:0] ports,
  input  logic [WR_AW_MAX-1:0]  idx,
  output logic                  we_c,
  output logic [DW-1:0]         data_c
);

  // Bundle data beyond DW is zero padding; fold it into a sink.
  logic unused_ports;
  assign unused_ports = ^ports;

  // Later (higher-index) ports overwrite earlier matches.
  always_comb begin
    we_c   = 1'b0;
    data_c = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (ports[p].en && (ports[p].addr == idx)) begin
        we_c   = 1'b1;
        data_c = ports[p].data[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_mw.sv
// regfile_mw: multi-write-port register file with per-register busy bits.
//   clk_i, arst_i        - clock, asynchronous active-high reset
//   wr_en/addr/data_i    - NUM_WR write-back ports, highest index wins
//   rsv_en_i, rsv_addr_i - mark a destination busy (wins over a same-cycle write)
//   rs_addr_i            - NUM_RS combinational read ports
//   rs_data_o, rs_busy_o - read data and pending flag per read port
//   busy_o               - registered scoreboard vector
// Build option: define REGFILE_MW_BYPASS_EN to forward same-cycle write data
// to the read ports (and report them not busy).
module regfile_mw
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_RS    = 3,
  parameter int unsigned NUM_WR    = 2,
  parameter bit          ZERO_REG  = 1'b1,
  parameter int unsigned NUM_REG   = 32,
  parameter int unsigned REG_WIDTH = 32,
  localparam int unsigned AW       = addr_width(NUM_REG)
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]         wr_addr_i,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0]  wr_data_i,
  input  logic                              rsv_en_i,
  input  logic [AW-1:0]                     rsv_addr_i,
  input  logic [NUM_RS-1:0][AW-1:0]         rs_addr_i,
  output logic [NUM_RS-1:0][REG_WIDTH-1:0]  rs_data_o,
  output logic [NUM_RS-1:0]                 rs_busy_o,
  output logic [NUM_REG-1:0]                busy_o
);

  wr_port_t [NUM_WR-1:0]               wr_bus;
  logic [NUM_REG-1:0][REG_WIDTH-1:0]   regs_q;
  logic [NUM_REG-1:0]                  busy_q;
  logic [NUM_REG-1:0]                  reg_we;
  logic [NUM_REG-1:0][REG_WIDTH-1:0]   reg_wdata;
  logic [NUM_REG-1:0]                  rsv_hit;
  logic [NUM_RS-1:0]                   rd_ok;

  // Pack the flat write ports into shared bundles.
  always_comb begin
    wr_bus = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      wr_bus[p].en   = wr_en_i[p];
      wr_bus[p].addr = WR_AW_MAX'(wr_addr_i[p]);
      wr_bus[p].data = WR_DW_MAX'(wr_data_i[p]);
    end
  end

  // Per-register write select and reservation decode. Indices only run to
  // NUM_REG-1, so out-of-range addresses never hit anything.
  for (genvar r = 0; r < int'(NUM_REG); r++) begin : g_reg
    if (ZERO_REG && (r == 0)) begin : g_zero
      assign reg_we[r]    = 1'b0;
      assign reg_wdata[r] = '0;
      assign rsv_hit[r]   = 1'b0;
    end else begin : g_live
      regfile_wr_sel #(
        .NUM_WR (NUM_WR),
        .DW     (REG_WIDTH)
      ) u_sel (
        .ports  (wr_bus),
        .idx    (WR_AW_MAX'(r)),
        .we_c   (reg_we[r]),
        .data_c (reg_wdata[r])
      );
      assign rsv_hit[r] = rsv_en_i && (rsv_addr_i == AW'(r));
    end
  end

  // Storage and scoreboard; reserve beats a same-cycle write on busy.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REG); r++) begin
        if (reg_we[r]) begin
          regs_q[r] <= reg_wdata[r];
        end
        if (rsv_hit[r]) begin
          busy_q[r] <= 1'b1;
        end else if (reg_we[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_o = busy_q;

`ifdef REGFILE_MW_BYPASS_EN
  logic [NUM_RS-1:0]                 byp_we;
  logic [NUM_RS-1:0][REG_WIDTH-1:0]  byp_data;

  // Same priority select, indexed by the live read address.
  for (genvar k = 0; k < int'(NUM_RS); k++) begin : g_byp
    regfile_wr_sel #(
      .NUM_WR (NUM_WR),
      .DW     (REG_WIDTH)
    ) u_byp (
      .ports  (wr_bus),
      .idx    (WR_AW_MAX'(rs_addr_i[k])),
      .we_c   (byp_we[k]),
      .data_c (byp_data[k])
    );
  end
`endif

  // Read ports: out-of-range and hardwired-zero addresses read 0, not busy.
  always_comb begin
    rd_ok     = '0;
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int k = 0; k < int'(NUM_RS); k++) begin
      rd_ok[k] = ((AW+1)'(rs_addr_i[k]) < (AW+1)'(NUM_REG)) &&
                 !(ZERO_REG && (rs_addr_i[k] == '0));
      if (rd_ok[k]) begin
        rs_data_o[k] = regs_q[rs_addr_i[k]];
        rs_busy_o[k] = busy_q[rs_addr_i[k]];
`ifdef REGFILE_MW_BYPASS_EN
        if (byp_we[k]) begin
          rs_data_o[k] = byp_data[k];
          rs_busy_o[k] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mw.sv
// tb_regfile_mw: directed scenarios on the default configuration plus a
// random soak of a 24-register, 3-write-port, no-zero-register instance
// against a reference model. Expectations are queued and compared as the
// outputs become valid.
module tb_regfile_mw;

  logic clk;
  logic arst;

  // Instance A: defaults (32 regs, 2 write ports, zero register on)
  logic [1:0]        a_wr_en;
  logic [1:0][4:0]   a_wr_addr;
  logic [1:0][31:0]  a_wr_data;
  logic              a_rsv_en;
  logic [4:0]        a_rsv_addr;
  logic [2:0][4:0]   a_rs_addr;
  logic [2:0][31:0]  a_rs_data;
  logic [2:0]        a_rs_busy;
  logic [31:0]       a_busy;

  // Instance B: 24 regs, 3 write ports, zero register off
  logic [2:0]        b_wr_en;
  logic [2:0][4:0]   b_wr_addr;
  logic [2:0][31:0]  b_wr_data;
  logic              b_rsv_en;
  logic [4:0]        b_rsv_addr;
  logic [2:0][4:0]   b_rs_addr;
  logic [2:0][31:0]  b_rs_data;
  logic [2:0]        b_rs_busy;
  logic [23:0]       b_busy;

  regfile_mw u_dut_a (
    .clk_i      (clk),
    .arst_i     (arst),
    .wr_en_i    (a_wr_en),
    .wr_addr_i  (a_wr_addr),
    .wr_data_i  (a_wr_data),
    .rsv_en_i   (a_rsv_en),
    .rsv_addr_i (a_rsv_addr),
    .rs_addr_i  (a_rs_addr),
    .rs_data_o  (a_rs_data),
    .rs_busy_o  (a_rs_busy),
    .busy_o     (a_busy)
  );

  regfile_mw #(
    .NUM_RS    (3),
    .NUM_WR    (3),
    .ZERO_REG  (1'b0),
    .NUM_REG   (24),
    .REG_WIDTH (32)
  ) u_dut_b (
    .clk_i      (clk),
    .arst_i     (arst),
    .wr_en_i    (b_wr_en),
    .wr_addr_i  (b_wr_addr),
    .wr_data_i  (b_wr_data),
    .rsv_en_i   (b_rsv_en),
    .rsv_addr_i (b_rsv_addr),
    .rs_addr_i  (b_rs_addr),
    .rs_data_o  (b_rs_data),
    .rs_busy_o  (b_rs_busy),
    .busy_o     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: which output to observe and the value it must hold.
  localparam int K_DATA  = 0;
  localparam int K_RBUSY = 1;
  localparam int K_BVEC  = 2;
  localparam int K_BBIT  = 3;

  typedef struct {
    int          kind;
    int          dut;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int dut, input int idx,
                      input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.dut  = dut;
    e.idx  = idx;
    e.val  = val;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic logic [31:0] observe(input int kind, input int dut, input int idx);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_DATA:  v = (dut != 0) ? b_rs_data[idx] : a_rs_data[idx];
      K_RBUSY: v = (dut != 0) ? 32'(b_rs_busy[idx]) : 32'(a_rs_busy[idx]);
      K_BVEC:  v = (dut != 0) ? 32'(b_busy) : a_busy;
      K_BBIT:  v = (dut != 0) ? 32'(b_busy[idx]) : 32'(a_busy[idx]);
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic drain();
    exp_t  e;
    string t;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, observe(e.kind, e.dut, e.idx), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en    = '0;
    a_wr_addr  = '0;
    a_wr_data  = '0;
    a_rsv_en   = 1'b0;
    a_rsv_addr = '0;
  endtask

  task automatic idle_b();
    b_wr_en    = '0;
    b_wr_addr  = '0;
    b_wr_data  = '0;
    b_rsv_en   = 1'b0;
    b_rsv_addr = '0;
    b_rs_addr  = '0;
  endtask

  // Address mix that favours collisions and reaches the unmapped range.
  function automatic logic [4:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6)      return 5'($urandom_range(0, 7));
    else if (r < 8) return 5'($urandom_range(8, 23));
    else            return 5'($urandom_range(24, 31));
  endfunction

  // Reference model for instance B
  logic [31:0] m_reg  [24];
  logic        m_busy [24];

  initial begin
    logic [31:0] ed;
    logic        eb;
    logic [23:0] mv;
    int          a;

    arst = 1'b1;
    idle_a();
    idle_b();
    a_rs_addr = '0;
    for (int r = 0; r < 24; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end

    // Reset state
    #2;
    a_rs_addr[0] = 5'd5;
    a_rs_addr[1] = 5'd31;
    #1;
    push("rst_data_r5", K_DATA, 0, 0, 32'h0);
    push("rst_data_r31", K_DATA, 0, 1, 32'h0);
    push("rst_busy_vec", K_BVEC, 0, 0, 32'h0);
    drain();
    tick();
    arst = 1'b0;

    // Write-port priority: port 1 beats port 0 on the same register
    a_wr_en      = 2'b11;
    a_wr_addr[0] = 5'd7;
    a_wr_data[0] = 32'hAAAA_0000;
    a_wr_addr[1] = 5'd7;
    a_wr_data[1] = 32'h5555_1111;
    tick();
    idle_a();
    a_rs_addr = {5'd7, 5'd7, 5'd7};
    #1;
    for (int k = 0; k < 3; k++) push("prio_data", K_DATA, 0, k, 32'h5555_1111);
    push("prio_busy", K_RBUSY, 0, 0, 32'h0);
    drain();

    // Reserve r3
    a_rsv_en   = 1'b1;
    a_rsv_addr = 5'd3;
    tick();
    idle_a();
    a_rs_addr[0] = 5'd3;
    #1;
    push("rsv_r3_rbusy", K_RBUSY, 0, 0, 32'h1);
    push("rsv_r3_bbit", K_BBIT, 0, 3, 32'h1);
    drain();

    // Write r3 clears busy
    a_wr_en[0]   = 1'b1;
    a_wr_addr[0] = 5'd3;
    a_wr_data[0] = 32'h0000_1234;
    tick();
    idle_a();
    #1;
    push("wr_r3_data", K_DATA, 0, 0, 32'h0000_1234);
    push("wr_r3_rbusy", K_RBUSY, 0, 0, 32'h0);
    drain();

    // Reserve and write r4 together: data lands, busy stays set
    a_wr_en[1]   = 1'b1;
    a_wr_addr[1] = 5'd4;
    a_wr_data[1] = 32'h0000_BEEF;
    a_rsv_en     = 1'b1;
    a_rsv_addr   = 5'd4;
    tick();
    idle_a();
    a_rs_addr[1] = 5'd4;
    #1;
    push("rsvwr_r4_data", K_DATA, 0, 1, 32'h0000_BEEF);
    push("rsvwr_r4_rbusy", K_RBUSY, 0, 1, 32'h1);
    drain();

    // Zero register: writes and reservations to r0 ignored, never bypassed
    a_wr_en[1]   = 1'b1;
    a_wr_addr[1] = 5'd0;
    a_wr_data[1] = 32'hFFFF_FFFF;
    a_rsv_en     = 1'b1;
    a_rsv_addr   = 5'd0;
    a_rs_addr[2] = 5'd0;
    #1;
    push("r0_same_data", K_DATA, 0, 2, 32'h0);
    push("r0_same_rbusy", K_RBUSY, 0, 2, 32'h0);
    drain();
    tick();
    idle_a();
    #1;
    push("r0_data", K_DATA, 0, 2, 32'h0);
    push("r0_rbusy", K_RBUSY, 0, 2, 32'h0);
    push("r0_bbit", K_BBIT, 0, 0, 32'h0);
    drain();

    // Bypass: busy r9 written while all read ports look at it
    a_rsv_en   = 1'b1;
    a_rsv_addr = 5'd9;
    tick();
    idle_a();
    a_rs_addr    = {5'd9, 5'd9, 5'd9};
    a_wr_en[0]   = 1'b1;
    a_wr_addr[0] = 5'd9;
    a_wr_data[0] = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_MW_BYPASS_EN
    ed = 32'hDEAD_BEEF;
    eb = 1'b0;
`else
    ed = 32'h0;
    eb = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      push("byp_same_data", K_DATA, 0, k, ed);
      push("byp_same_rbusy", K_RBUSY, 0, k, 32'(eb));
    end
    push("byp_same_bbit", K_BBIT, 0, 9, 32'h1);
    drain();
    tick();
    idle_a();
    #1;
    for (int k = 0; k < 3; k++) push("byp_next_data", K_DATA, 0, k, 32'hDEAD_BEEF);
    push("byp_next_rbusy", K_RBUSY, 0, 0, 32'h0);
    push("byp_next_bbit", K_BBIT, 0, 9, 32'h0);
    drain();

    // Mid-traffic reset: state clears immediately, pending update discarded
    a_rs_addr    = {5'd4, 5'd3, 5'd7};
    a_wr_en[0]   = 1'b1;
    a_wr_addr[0] = 5'd5;
    a_wr_data[0] = 32'h0000_0077;
    a_rsv_en     = 1'b1;
    a_rsv_addr   = 5'd5;
    #1;
    push("pre_rst_busy_vec", K_BVEC, 0, 0, 32'h0000_0010);
    drain();
    arst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) push("arst_data", K_DATA, 0, k, 32'h0);
    push("arst_busy_vec", K_BVEC, 0, 0, 32'h0);
    drain();
    tick();
    arst = 1'b0;
    idle_a();
    a_rs_addr[0] = 5'd5;
    #1;
    push("post_rst_r5_data", K_DATA, 0, 0, 32'h0);
    push("post_rst_r5_rbusy", K_RBUSY, 0, 0, 32'h0);
    drain();

    // Random soak of instance B against the model
    for (int i = 0; i < 10000; i++) begin
      for (int p = 0; p < 3; p++) begin
        b_wr_en[p]   = 1'($urandom_range(0, 1));
        b_wr_addr[p] = pick_addr();
        b_wr_data[p] = $urandom;
      end
      b_rsv_en   = 1'($urandom_range(0, 1));
      b_rsv_addr = pick_addr();
      for (int k = 0; k < 3; k++) b_rs_addr[k] = pick_addr();
      #1;
      for (int k = 0; k < 3; k++) begin
        a  = int'(b_rs_addr[k]);
        ed = '0;
        eb = 1'b0;
        if (a < 24) begin
          ed = m_reg[a];
          eb = m_busy[a];
`ifdef REGFILE_MW_BYPASS_EN
          for (int p = 0; p < 3; p++) begin
            if (b_wr_en[p] && (int'(b_wr_addr[p]) == a)) begin
              ed = b_wr_data[p];
              eb = 1'b0;
            end
          end
`endif
        end
        push("soak_data", K_DATA, 1, k, ed);
        push("soak_rbusy", K_RBUSY, 1, k, 32'(eb));
      end
      for (int r = 0; r < 24; r++) mv[r] = m_busy[r];
      push("soak_busy_vec", K_BVEC, 1, 0, {8'h0, mv});
      drain();
      for (int p = 0; p < 3; p++) begin
        if (b_wr_en[p] && (int'(b_wr_addr[p]) < 24)) begin
          m_reg[int'(b_wr_addr[p])]  = b_wr_data[p];
          m_busy[int'(b_wr_addr[p])] = 1'b0;
        end
      end
      if (b_rsv_en && (int'(b_rsv_addr) < 24)) m_busy[int'(b_rsv_addr)] = 1'b1;
      tick();
    end
    idle_b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mw.md
# regfile_mw

Multi-write-port register file with per-register scoreboard (busy) bits. It is the generalised successor of the single-write register file, for superscalar or multi-unit cores. It adds NUM_WR independent write ports with fixed priority, a destination-reservation port that marks registers pending until written back, and optional same-cycle write-to-read bypass. It sits between issue/decode (reservation, operand read) and the write-back units.

## Interface
- NUM_RS, 3, number of read (source) ports
- NUM_WR, 2, number of write-back ports
- ZERO_REG, 1, register 0 hardwired to zero and never busy
- NUM_REG, 32, number of registers (>=2)
- REG_WIDTH, 32, bits per register
- AW (localparam), $clog2(NUM_REG), address width

- clk_i  in  1  clock, all state updates on rising edge
- arst_i  in  1  asynchronous reset, active-high
- wr_en_i  in  [NUM_WR]  write-port enables
- wr_addr_i  in  [NUM_WR][AW]  write addresses
- wr_data_i  in  [NUM_WR][REG_WIDTH]  write data
- rsv_en_i  in  1  reserve destination register (set busy)
- rsv_addr_i  in  [AW]  register to reserve
- rs_addr_i  in  [NUM_RS][AW]  read addresses
- rs_data_o  out  [NUM_RS][REG_WIDTH]  read data
- rs_busy_o  out  [NUM_RS]  addressed register is pending
- busy_o  out  [NUM_REG]  full scoreboard vector

## Operation
- Reset (arst_i=1): all registers = 0, all busy bits = 0, immediately and asynchronously. Outputs therefore read 0 / not-busy during reset.
- Write: on a clock edge, each register is loaded by the highest-index enabled write port whose address matches it. Lower-index ports to the same address are dropped. There is no error flag.
- A write clears the busy bit of the written register.
- Reserve: rsv_en_i sets busy[rsv_addr_i] on the edge.
- Same register written and reserved in one cycle: data is written and busy ends set, because reserve wins (new producer).
- Reserving an already-busy register leaves it busy.
- ZERO_REG=1:
  - writes and reservations to address 0 are ignored
  - rs_data_o reads 0 and rs_busy_o is 0 for address 0
  - busy_o[0] is constant 0
- Reads are combinational from registered state, plus the bypass below when compiled in.
- Addresses >= NUM_REG (non-power-of-2 NUM_REG):
  - writes and reservations are ignored
  - reads return 0, not busy

## Timing
- Write and reservation latency: 1 cycle. The value and busy change are visible on rs_data_o/busy_o the cycle after the edge; with bypass, data is visible in the same cycle.
- Read latency: 0 cycles (combinational).
- No handshake. Every port is accepted every cycle.
- Reset mid-operation discards all pending writes and reservations and clears the scoreboard.

## Configuration
- REGFILE_MW_BYPASS_EN defined:
  - If any enabled write port targets rs_addr_i[k] in the current cycle, rs_data_o[k] returns that port's data (highest-index port wins) and rs_busy_o[k]=0.
  - A same-cycle reservation does not affect the read outputs.
  - Address 0 with ZERO_REG is never bypassed.
- Not defined:
  - rs_data_o and rs_busy_o reflect registered state only.
  - A same-cycle write is invisible until the next cycle.
  - busy_o is always registered state in both builds.

## Structure
- Shared package regfile_pkg holds:
  - the address-width helper function
  - a typedef for the write-port bundle (en, addr, data)
- One sub-module, regfile_wr_sel: per-register priority select. Inputs are the NUM_WR enables, addresses and data plus a constant register index. Outputs are the write-enable and selected data for that register. It is reused by the bypass path with rs_addr_i as the index.
- Storage uses the existing register primitive (reset value '0). The busy bits are a flat flop vector in the top level.

## Test plan
- Reset: drive arst_i=1 mid-traffic -> every rs_data_o=0, busy_o=0 immediately. After release, read of r5 = 0.
- Write-port priority: wr0 writes r7=0xAAAA_0000 and wr1 writes r7=0x5555_1111 in the same cycle -> next cycle r7 reads 0x5555_1111.
- Scoreboard: reserve r3 -> next cycle rs_busy_o=1 for r3. Write r3=0x1234 -> next cycle busy clear, data 0x1234. Reserve and write r4 in the same cycle -> r4 busy, data updated.
- Zero register (ZERO_REG=1): write r0=0xFFFF_FFFF and reserve r0 -> r0 reads 0, busy_o[0]=0. Repeat with ZERO_REG=0 -> r0 reads 0xFFFF_FFFF, busy.
- Bypass: with REGFILE_MW_BYPASS_EN, busy r9 written 0xDEAD_BEEF while all three read ports address r9 -> same cycle 0xDEAD_BEEF, busy 0. Without the macro -> old value and busy=1 that cycle, new value the next cycle.
- Random soak: NUM_REG=24, NUM_WR=3, 10k cycles against a reference model, including out-of-range addresses 24..31 -> no mismatches.
